// File: rtl/assign_chain_pkg.sv
// assign_chain_pkg
//   Shared definitions for the assignment-chain checker:
//     state_e        FSM states IDLE -> RUN -> DONE -> IDLE
//     MODE_NB        nonblocking (true pipeline) chain update
//     MODE_BLK       blocking, head-first chain update
//     expected_tail  model of the chain tail after RUN edge k
package assign_chain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MODE_NB  = 0;
  localparam int MODE_BLK = 1;

  // Tail after injecting seed+k on edge k. A pipeline lags the head by
  // depth-1 stages; a blocking chain collapses to the head value.
  // Computed at 64 bits; callers truncate to their data width (WIDTH <= 64).
  function automatic logic [63:0] expected_tail(input logic [63:0] seed,
                                                input logic [63:0] k,
                                                input int          depth,
                                                input int          mode);
    logic [63:0] lag;
    lag = (mode == MODE_NB) ? 64'(depth - 1) : 64'd0;
    return seed + k - lag;
  endfunction

endpackage

// File: rtl/assign_chain_stages.sv
// assign_chain_stages
//   DEPTH x WIDTH register chain. Stage 0 takes i_inj; the remaining stages
//   follow either pipeline (MODE_NB) or head-first blocking (MODE_BLK) order.
//   i_fault flips bit 0 of the value written into stage DEPTH/2.
//   Ports: clk, rst_n (async low), i_en (update enable), i_fault,
//          i_inj [WIDTH] head value, o_tail [WIDTH] last stage.
module assign_chain_stages
  import assign_chain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = MODE_NB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_fault,
  input  logic [WIDTH-1:0] i_inj,
  output logic [WIDTH-1:0] o_tail
);

  localparam int FLIP = DEPTH / 2;

  logic [DEPTH-1:0][WIDTH-1:0] r_stg;
  logic [DEPTH-1:0][WIDTH-1:0] w_nxt;

  generate
    if (MODE == MODE_BLK) begin : g_blk
      // Blocking order: the flip lands first, then the head value is copied
      // down the whole chain, so the flip never survives the cycle.
      always_comb begin
        w_nxt          = r_stg;
        w_nxt[FLIP][0] = w_nxt[FLIP][0] ^ i_fault;
        w_nxt[0]       = i_inj;
        for (int i = 1; i < DEPTH; i++) w_nxt[i] = w_nxt[i-1];
      end
    end else begin : g_nb
      // Pipeline order: every stage takes its predecessor's old value.
      always_comb begin
        w_nxt[0] = i_inj;
        for (int i = 1; i < DEPTH; i++) w_nxt[i] = r_stg[i-1];
        w_nxt[FLIP][0] = w_nxt[FLIP][0] ^ i_fault;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_stg <= '0;
    else if (i_en) r_stg <= w_nxt;
  end

  assign o_tail = r_stg[DEPTH-1];

endmodule

// File: rtl/assign_chain_checker.sv
// assign_chain_checker
//   Drives a DEPTH-stage chain for 2*DEPTH RUN cycles, injecting seed+k on
//   each edge, and compares the tail against a built-in model every cycle.
//   Ports: clk, rst_n (async low), start (sampled in IDLE), seed [WIDTH],
//          fault (flip during RUN), busy, done (1-cycle pulse),
//          result [WIDTH] (tail at end of run), ERROR (sticky mismatch).
module assign_chain_checker
  import assign_chain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = MODE_NB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic             fault,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ERROR
);

  localparam int RUN_CYC = 2 * DEPTH;
  localparam int KW      = $clog2(RUN_CYC);
  localparam logic [KW-1:0] K_LAST = KW'(RUN_CYC - 1);

  state_e           r_state;
  logic [KW-1:0]    r_k;
  logic [KW-1:0]    r_chk_k;
  logic             r_chk_vld;
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  logic             w_run;
  logic             w_fault;
  logic             w_chk_en;
  logic [WIDTH-1:0] w_inj;
  logic [WIDTH-1:0] w_tail;
  logic [WIDTH-1:0] w_exp;

  assign w_run    = (r_state == RUN);
  assign w_fault  = fault & w_run;
  assign w_inj    = r_seed + WIDTH'(r_k);
  // The pipeline tail holds stale data until the first injection reaches it.
  assign w_chk_en = (MODE == MODE_BLK) || (r_k >= KW'(DEPTH - 1));
  assign w_exp    = WIDTH'(expected_tail(64'(r_seed), 64'(r_chk_k), DEPTH, MODE));

  assign_chain_stages #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .MODE  (MODE)
  ) u_stages (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_run),
    .i_fault (w_fault),
    .i_inj   (w_inj),
    .o_tail  (w_tail)
  );

  // The tail written on edge k is compared in the following cycle, so the
  // check for the last RUN edge completes on the DONE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_chk_k   <= '0;
      r_chk_vld <= 1'b0;
      r_seed    <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_chk_vld <= 1'b0;
      if (r_chk_vld && (w_tail != w_exp)) r_error <= 1'b1;
      case (r_state)
        IDLE: begin
          r_busy <= start;
          if (start) begin
            r_seed  <= seed;
            r_k     <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_busy    <= 1'b1;
          r_chk_vld <= w_chk_en;
          r_chk_k   <= r_k;
          r_k       <= r_k + 1'b1;
          if (r_k == K_LAST) r_state <= DONE;
        end
        DONE: begin
          // busy stays high through this edge and drops on the next IDLE edge
          r_busy   <= 1'b1;
          r_done   <= 1'b1;
          r_result <= w_tail;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign ERROR  = r_error;

endmodule
